// File: rtl/ram_access_ctrl.sv
// Burst initiator for the asynchronous 32x32 RAM.
// Drives writeOn as a registered 1-cycle strobe and streams read words out.
module ram_access_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              ram_writeOn
);

    typedef enum logic [2:0] {
        IDLE, WWAIT, WSETUP, WSTROBE, WHOLD, RADDR, RCAP, RVALID
    } state_e;

    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              rv_q, rv_d;
    logic              done_q, done_d;
    logic              wrdy_q, wrdy_d;
    logic              crdy_q, crdy_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        cnt_d   = cnt_q;
        rv_d    = rv_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr & AMASK;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? WWAIT : RADDR;
                end
            end
            WWAIT: begin
                if (wr_valid) begin
                    wdat_d  = wr_data;
                    state_d = WSETUP;
                end
            end
            WSETUP: begin
                we_d    = 1'b1;
                state_d = WSTROBE;
            end
            WSTROBE: begin
                state_d = WHOLD;
            end
            WHOLD: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    addr_d  = (addr_q + ADDR_W'(1)) & AMASK;
                    state_d = WWAIT;
                end
            end
            RADDR: begin
                state_d = RCAP;
            end
            RCAP: begin
                rdat_d  = ram_data_out;
                rv_d    = 1'b1;
                state_d = RVALID;
            end
            RVALID: begin
                if (rd_ready) begin
                    rv_d = 1'b0;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        addr_d  = (addr_q + ADDR_W'(1)) & AMASK;
                        state_d = RADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        wrdy_d = (state_d == WWAIT);
        crdy_d = (state_d == IDLE);
    end

    // State and output registers; reset drops writeOn immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
            wrdy_q  <= 1'b0;
            crdy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
            wrdy_q  <= wrdy_d;
            crdy_q  <= crdy_d;
        end
    end

    assign cmd_ready   = crdy_q;
    assign wr_ready    = wrdy_q;
    assign rd_data     = rdat_q;
    assign rd_valid    = rv_q;
    assign done        = done_q;
    assign ram_address = addr_q;
    assign ram_data_in = wdat_q;
    assign ram_writeOn = we_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl.
// Models the async RAM and keeps an expected memory image.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [5:0]  cmd_addr = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        done;
    logic [5:0]  ram_address;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic        ram_writeOn;

    int total = 0;
    int bad = 0;
    int tmo = 0;

    ram_access_ctrl #(
        .ADDR_W(6), .DATA_W(32), .DEPTH(32), .LEN_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_writeOn(ram_writeOn)
    );

    always #5 clk = ~clk;

    // RAM model plus write log
    logic [31:0] mem [32];
    logic [31:0] exp_mem [32];
    logic        mem_init = 1'b1;
    int          cyc = 0;
    logic [5:0]  wlog_a [$];
    logic [31:0] wlog_d [$];
    int          wlog_t [$];

    assign ram_data_out = mem[ram_address[4:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A50000 | i;
        end else if (ram_writeOn) begin
            mem[ram_address[4:0]] <= ram_data_in;
            wlog_a.push_back(ram_address);
            wlog_d.push_back(ram_data_in);
            wlog_t.push_back(cyc);
        end
    end

    // Protocol monitor: strobe width and address/data stability
    logic        p_valid = 1'b0;
    logic        p_we = 1'b0;
    logic [5:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    int          mon_err = 0;
    int          strobes = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_we    <= 1'b0;
        end else begin
            if (p_valid && ram_writeOn && p_we)
                mon_err <= mon_err + 1;
            if (p_valid && (ram_writeOn || p_we) &&
                (ram_address !== p_addr || ram_data_in !== p_data))
                mon_err <= mon_err + 1;
            if (done && !cmd_ready)
                mon_err <= mon_err + 1;
            if (ram_writeOn) strobes <= strobes + 1;
            if (done) done_cnt <= done_cnt + 1;
            p_valid <= 1'b1;
            p_we    <= ram_writeOn;
            p_addr  <= ram_address;
            p_data  <= ram_data_in;
        end
    end

    logic [31:0] wdata [32];
    logic [31:0] rq [$];

    task automatic write_burst(input logic [5:0] a, input int len,
                               input int stall, output int st_err);
        int w;
        st_err = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_len   = 5'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 6'($urandom);
        cmd_len   = 5'($urandom);
        cmd_write = 1'($urandom);
        for (int i = 0; i <= len; i++) begin
            for (int s = 0; s < stall; s++) begin
                wr_valid = 1'b0;
                @(negedge clk);
                if (wr_ready && (ram_writeOn !== 1'b0 ||
                    ram_address !== 6'((int'(a) % 32 + i) % 32)))
                    st_err++;
            end
            wr_valid = 1'b1;
            wr_data  = wdata[i];
            w = 0;
            while (!wr_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) tmo++;
            @(negedge clk);
            wr_valid = 1'b0;
            wr_data  = $urandom;
        end
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) tmo++;
        for (int i = 0; i <= len; i++)
            exp_mem[(int'(a) % 32 + i) % 32] = wdata[i];
    endtask

    task automatic read_burst(input logic [5:0] a, input int len,
                              input int bp, input bit noise,
                              output int lat, output int st_err);
        int w;
        logic [31:0] first;
        rq.delete();
        st_err = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        cmd_len   = 5'(len);
        @(negedge clk);
        lat = 1;
        if (noise) begin
            cmd_write = 1'b1;
            cmd_addr  = 6'($urandom);
            cmd_len   = 5'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        for (int i = 0; i <= len; i++) begin
            w = 0;
            while (!rd_valid && w < 50) begin
                @(negedge clk);
                w++;
                if (i == 0) lat++;
            end
            if (w >= 50) tmo++;
            cmd_valid = 1'b0;
            first = rd_data;
            for (int b = 0; b < bp; b++) begin
                @(negedge clk);
                if (rd_valid !== 1'b1 || rd_data !== first) st_err++;
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            rq.push_back(first);
            if (rd_valid !== 1'b0) st_err++;
        end
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) tmo++;
    endtask

    task automatic test_reset();
        total++;
        if ({cmd_ready, wr_ready, rd_valid, done, ram_writeOn} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=10000",
                     {cmd_ready, wr_ready, rd_valid, done, ram_writeOn});
        end
        total++;
        if (ram_address !== 6'd0) begin
            bad++;
            $display("FAIL reset_addr got=%0d want=0", ram_address);
        end
        total++;
        if (ram_data_in !== 32'd0) begin
            bad++;
            $display("FAIL reset_wdata got=%h want=0", ram_data_in);
        end
        total++;
        if (rd_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_rdata got=%h want=0", rd_data);
        end
    endtask

    task automatic test_single_write();
        int s0, d0, wl0, se, lat;
        s0  = strobes;
        d0  = done_cnt;
        wl0 = wlog_a.size();
        wdata[0] = 32'hDEADBEEF;
        write_burst(6'd5, 0, 0, se);
        @(negedge clk);
        total++;
        if (strobes - s0 != 1) begin
            bad++;
            $display("FAIL single_strobes got=%0d want=1", strobes - s0);
        end
        total++;
        if (wlog_a.size() != wl0 + 1 || wlog_a[wl0] !== 6'd5 ||
            wlog_d[wl0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_wlog n=%0d want=1 at addr 5",
                     wlog_a.size() - wl0);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL single_done got=%0d want=1", done_cnt - d0);
        end
        read_burst(6'd5, 0, 0, 1'b0, lat, se);
        total++;
        if (rq.size() != 1 || rq[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_read got=%h want=deadbeef", rq[0]);
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL read_latency got=%0d want=3", lat);
        end
    endtask

    task automatic test_burst_wrap();
        int wl0, se, lat, e;
        logic [5:0] ea [4];
        ea[0] = 6'd30; ea[1] = 6'd31; ea[2] = 6'd0; ea[3] = 6'd1;
        wl0 = wlog_a.size();
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        write_burst(6'd30, 3, 0, se);
        e = 0;
        if (wlog_a.size() != wl0 + 4) e++;
        else
            for (int i = 0; i < 4; i++)
                if (wlog_a[wl0+i] !== ea[i] || wlog_d[wl0+i] !== 32'(i + 1))
                    e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL wrap_writes errs=%0d want=0", e);
        end
        e = 0;
        for (int i = 0; i < 3; i++)
            if (wlog_t[wl0+i+1] - wlog_t[wl0+i] != 4) e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL write_rate errs=%0d want=0 (4 cycles/word)", e);
        end
        read_burst(6'd30, 3, 0, 1'b0, lat, se);
        e = 0;
        if (rq.size() != 4) e++;
        else
            for (int i = 0; i < 4; i++)
                if (rq[i] !== 32'(i + 1)) e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL wrap_read errs=%0d want=0", e);
        end
    endtask

    task automatic test_backpressure();
        int se, lat, e;
        for (int i = 0; i < 3; i++) wdata[i] = $urandom;
        write_burst(6'd8, 2, 0, se);
        read_burst(6'd8, 2, 5, 1'b0, lat, se);
        total++;
        if (se != 0) begin
            bad++;
            $display("FAIL bp_stable errs=%0d want=0", se);
        end
        e = 0;
        if (rq.size() != 3) e++;
        else
            for (int i = 0; i < 3; i++)
                if (rq[i] !== exp_mem[8 + i]) e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL bp_data errs=%0d words=%0d want=3", e, rq.size());
        end
    endtask

    task automatic test_write_stall();
        int se, wl0, e;
        wl0 = wlog_a.size();
        for (int i = 0; i < 3; i++) wdata[i] = $urandom;
        write_burst(6'd20, 2, 4, se);
        total++;
        if (se != 0) begin
            bad++;
            $display("FAIL stall_wait errs=%0d want=0", se);
        end
        e = 0;
        if (wlog_a.size() != wl0 + 3) e++;
        else
            for (int i = 0; i < 3; i++)
                if (wlog_a[wl0+i] !== 6'(20 + i) || wlog_d[wl0+i] !== wdata[i])
                    e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL stall_writes errs=%0d want=0", e);
        end
    endtask

    task automatic test_reset_mid();
        int n, k, w, se, lat, e;
        logic [31:0] old11;
        for (int i = 0; i < 4; i++) wdata[i] = $urandom;
        old11 = exp_mem[11];
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 6'd10;
        cmd_len   = 5'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        n = 0; k = 0; w = 0;
        while (n < 2 && w < 100) begin
            if (ram_writeOn) n++;
            if (n < 2) begin
                if (wr_ready && k < 4) begin
                    wr_data = wdata[k];
                    k++;
                end
                @(negedge clk);
                w++;
            end
        end
        total++;
        if (n != 2 || ram_address !== 6'd11) begin
            bad++;
            $display("FAIL mid_reach strobes=%0d addr=%0d want 2 at 11",
                     n, ram_address);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ram_writeOn !== 1'b0) begin
            bad++;
            $display("FAIL mid_we_drop got=%b want=0", ram_writeOn);
        end
        total++;
        if ({cmd_ready, wr_ready, rd_valid, done, ram_address,
             ram_data_in, rd_data} !== {4'b1000, 6'd0, 64'd0}) begin
            bad++;
            $display("FAIL mid_outputs rdy=%b wr=%b addr=%0d want reset",
                     cmd_ready, wr_ready, ram_address);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (mem[10] !== wdata[0] || mem[12] !== exp_mem[12] ||
            mem[13] !== exp_mem[13] ||
            (mem[11] !== old11 && mem[11] !== wdata[1])) begin
            bad++;
            $display("FAIL mid_partial m10=%h m12=%h m13=%h want %h %h %h",
                     mem[10], mem[12], mem[13], wdata[0], exp_mem[12],
                     exp_mem[13]);
        end
        exp_mem[10] = wdata[0];
        exp_mem[11] = (mem[11] === wdata[1]) ? wdata[1] : old11;
        wdata[0] = 32'h0BADF00D;
        write_burst(6'd12, 0, 0, se);
        read_burst(6'd10, 3, 0, 1'b0, lat, se);
        e = 0;
        if (rq.size() != 4) e++;
        else
            for (int i = 0; i < 4; i++)
                if (rq[i] !== exp_mem[10 + i]) e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL mid_after errs=%0d want=0", e);
        end
    endtask

    task automatic test_random();
        int se, lat, e, wl0, s0, len;
        logic [5:0] a;
        e = 0;
        for (int it = 0; it < 12; it++) begin
            a   = 6'($urandom);
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) wdata[i] = $urandom;
                wl0 = wlog_a.size();
                write_burst(a, len, $urandom_range(0, 2), se);
                if (se != 0 || wlog_a.size() != wl0 + len + 1) e++;
                else
                    for (int i = 0; i <= len; i++)
                        if (wlog_a[wl0+i] !== 6'((int'(a) % 32 + i) % 32) ||
                            wlog_d[wl0+i] !== wdata[i])
                            e++;
            end else begin
                s0 = strobes;
                read_burst(a, len, $urandom_range(0, 2), 1'($urandom),
                           lat, se);
                @(negedge clk);
                if (se != 0 || lat != 3 || strobes != s0 ||
                    rq.size() != len + 1) e++;
                else
                    for (int i = 0; i <= len; i++)
                        if (rq[i] !== exp_mem[(int'(a) % 32 + i) % 32]) e++;
            end
        end
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL random_bursts errs=%0d want=0", e);
        end
        read_burst(6'd0, 31, 0, 1'b0, lat, se);
        e = 0;
        if (rq.size() != 32) e++;
        else
            for (int i = 0; i < 32; i++)
                if (rq[i] !== exp_mem[i]) e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL full_read errs=%0d words=%0d want=32", e, rq.size());
        end
    endtask

    task automatic test_protocol();
        @(negedge clk);
        total++;
        if (mon_err != 0) begin
            bad++;
            $display("FAIL protocol violations=%0d want=0", mon_err);
        end
        total++;
        if (tmo != 0) begin
            bad++;
            $display("FAIL timeouts got=%0d want=0", tmo);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'hA5A50000 | i;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
        test_single_write();
        test_burst_wrap();
        test_backpressure();
        test_write_stall();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
